// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT bank scheduler: lane/bank sizes, FSM states,
// and the index-to-bank/address mapping.
package ntt_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH
    } state_e;

    function automatic int unsigned nstg(input int unsigned aw);
        return aw + 32'd3;
    endfunction

    // Butterfly operand index: k with a zero inserted at bit s, optionally with bit s set.
    function automatic logic [31:0] lane_index(input logic [31:0] k, input logic [31:0] s,
                                               input logic upper);
        logic [31:0] low_mask;
        logic [31:0] lo;
        low_mask = (32'd1 << s) - 32'd1;
        lo       = ((k & ~low_mask) << 1) | (k & low_mask);
        return upper ? (lo | (32'd1 << s)) : lo;
    endfunction

    // Upper bits of idx are zero, so the parity over [31:2] equals the parity over [n-1:2].
    function automatic logic [SEL_W-1:0] bank_of(input logic [31:0] idx);
        return {^idx[31:2], idx[1], idx[0]};
    endfunction

    function automatic logic [31:0] addr_of(input logic [31:0] idx);
        return idx >> 3;
    endfunction

endpackage

// File: rtl/ntt_bank_sched_if.sv
// Control handshake plus read and write-back bank bundles of the NTT scheduler.
interface ntt_bank_sched_if #(
    parameter int unsigned AW = 7
);
    import ntt_pkg::*;

    logic                        start;
    logic                        hold;
    logic                        busy;
    logic                        done;
    logic                        rd_valid;
    logic [LANES-1:0][AW-1:0]    rd_b;
    logic [LANES-1:0][SEL_W-1:0] rd_sel_a;
    logic [LANES-1:0][SEL_W-1:0] rd_lane_bank;
    logic                        wr_valid;
    logic [LANES-1:0][AW-1:0]    wr_b;
    logic [LANES-1:0][SEL_W-1:0] wr_sel_a;
    logic [LANES-1:0][SEL_W-1:0] wr_lane_bank;

    modport master (
        input  start, hold,
        output busy, done,
        output rd_valid, rd_b, rd_sel_a, rd_lane_bank,
        output wr_valid, wr_b, wr_sel_a, wr_lane_bank
    );

    modport slave (
        output start, hold,
        input  busy, done,
        input  rd_valid, rd_b, rd_sel_a, rd_lane_bank,
        input  wr_valid, wr_b, wr_sel_a, wr_lane_bank
    );

endinterface

// File: rtl/ntt_sched_delay.sv
// Fixed-depth shift register that turns the read bundle into the write-back bundle.
module ntt_sched_delay #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_bank_sched.sv
// Stage/cycle walker for the 4-BFU, 8-bank NTT: issues per-lane bank addresses and
// crossbar selects, with inter-stage bubbles and a BFU_LAT-delayed write-back copy.
module ntt_bank_sched
    import ntt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned BFU_LAT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    ntt_bank_sched_if.master  bus
);

    localparam int unsigned NSTG_L = nstg(ADDR_WIDTH);
    localparam int unsigned SW     = unsigned'($clog2(NSTG_L));
    localparam int unsigned CW     = unsigned'($clog2(BFU_LAT + 1)) + 32'd1;
    localparam int unsigned BW     = 1 + LANES * ADDR_WIDTH + 2 * LANES * SEL_W;

    state_e                              state_q, state_d;
    logic [SW-1:0]                       s_q, s_d;
    logic [ADDR_WIDTH-1:0]               c_q, c_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                rd_valid_q, rd_valid_d;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    rd_b_q, rd_b_d;
    logic [LANES-1:0][SEL_W-1:0]         rd_sel_q, rd_sel_d;
    logic [LANES-1:0][SEL_W-1:0]         rd_lb_q, rd_lb_d;

    logic [LANES-1:0][31:0]              idx_c;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    bnd_b_c;
    logic [LANES-1:0][SEL_W-1:0]         bnd_sel_c;
    logic [LANES-1:0][SEL_W-1:0]         bnd_lb_c;
    logic [BW-1:0]                       rd_bundle_c;
    logic [BW-1:0]                       wr_bundle_c;

    // Lane 2m carries the low operand of butterfly m, lane 2m+1 the high one.
    always_comb begin
        idx_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx_c[l] = lane_index((32'(c_q) << 2) + 32'(l / 2), 32'(s_q), (l % 2) == 1);
        end
    end

    // Bank map and its inverse for the bank-side crossbar.
    always_comb begin
        bnd_b_c   = '0;
        bnd_sel_c = '0;
        bnd_lb_c  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            bnd_b_c[l]                  = ADDR_WIDTH'(addr_of(idx_c[l]));
            bnd_lb_c[l]                 = bank_of(idx_c[l]);
            bnd_sel_c[bank_of(idx_c[l])] = SEL_W'(l);
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        c_d        = c_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_b_d     = '0;
        rd_sel_d   = '0;
        rd_lb_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!bus.hold) begin
                    rd_valid_d = 1'b1;
                    rd_b_d     = bnd_b_c;
                    rd_sel_d   = bnd_sel_c;
                    rd_lb_d    = bnd_lb_c;
                    c_d        = c_q + ADDR_WIDTH'(1);
                    if (c_q == '1) begin
                        cnt_d   = '0;
                        state_d = (s_q == SW'(NSTG_L - 1)) ? ST_FLUSH : ST_GAP;
                    end
                end
            end
            // Bubble long enough for the last write of the stage to land before the next read.
            ST_GAP: begin
                if (cnt_q == CW'(BFU_LAT)) begin
                    cnt_d   = '0;
                    s_d     = s_q + SW'(1);
                    c_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CW'(BFU_LAT - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_b_q     <= '0;
            rd_sel_q   <= '0;
            rd_lb_q    <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_b_q     <= rd_b_d;
            rd_sel_q   <= rd_sel_d;
            rd_lb_q    <= rd_lb_d;
        end
    end

    assign rd_bundle_c = {rd_valid_q, rd_b_q, rd_sel_q, rd_lb_q};

    ntt_sched_delay #(
        .W     (BW),
        .DEPTH (BFU_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rd_bundle_c),
        .q_o   (wr_bundle_c)
    );

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_b         = rd_b_q;
    assign bus.rd_sel_a     = rd_sel_q;
    assign bus.rd_lane_bank = rd_lb_q;
    assign {bus.wr_valid, bus.wr_b, bus.wr_sel_a, bus.wr_lane_bank} = wr_bundle_c;

endmodule

// File: tb/tb_ntt_bank_sched.sv
// Self-checking bench for ntt_bank_sched with addr_width=2, BFU_LAT=3.
module tb_ntt_bank_sched;

    localparam int AW  = 2;
    localparam int LAT = 3;
    localparam int NST = 5;
    localparam int NC  = 4;
    localparam int HW  = 1 + 8 * AW + 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_bank_sched_if #(.AW(AW)) bus();

    ntt_bank_sched #(.ADDR_WIDTH(AW), .BFU_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int s; int c; } sc_t;
    typedef struct { int s; int c; int b[8]; int lb[8]; int sel[8]; } vec_t;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int e0 = 0;
    bit mon_en = 1'b0;

    sc_t rdq[$];
    int  wrq[$];
    logic [HW-1:0] hist[3];
    logic [HW-1:0] rd_pack, wr_pack;
    int first_rd[NST];
    int last_rd, done_k, busy_fall;
    bit busy_prev;
    logic [15:0] cap_b  [NST][NC];
    logic [23:0] cap_lb [NST][NC];
    logic [23:0] cap_sel[NST][NC];
    bit          cap_ok [NST][NC];
    vec_t tbl[3];

    assign rd_pack = {bus.rd_valid, bus.rd_b, bus.rd_sel_a, bus.rd_lane_bank};
    assign wr_pack = {bus.wr_valid, bus.wr_b, bus.wr_sel_a, bus.wr_lane_bank};

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand index found by counting indices with bit s clear, not by bit insertion.
    function automatic void model(input int s, input int c, output int b[8], output int lb[8],
                                  output int sel[8]);
        int idx[8];
        for (int m = 0; m < 4; m++) begin
            int cnt, lo;
            cnt = 0;
            lo  = 0;
            for (int i = 0; i < 32; i++) begin
                if (((i >> s) & 1) == 0) begin
                    if (cnt == 4 * c + m) lo = i;
                    cnt++;
                end
            end
            idx[2*m]   = lo;
            idx[2*m+1] = lo + (1 << s);
        end
        for (int l = 0; l < 8; l++) begin
            lb[l]      = ($countones(idx[l] >> 2) % 2) * 4 + (idx[l] % 4);
            b[l]       = idx[l] / 8;
            sel[lb[l]] = l;
        end
    endfunction

    function automatic logic [15:0] pk2(input int a[8]);
        logic [15:0] r;
        for (int l = 0; l < 8; l++) r[2*l +: 2] = 2'(a[l]);
        return r;
    endfunction

    function automatic logic [23:0] pk3(input int a[8]);
        logic [23:0] r;
        for (int l = 0; l < 8; l++) r[3*l +: 3] = 3'(a[l]);
        return r;
    endfunction

    int  mk, mkr;
    bit  m_ok;
    logic [7:0] m_seen;
    sc_t m_e;
    int  m_b[8], m_lb[8], m_sel[8];

    // Per-cycle scoreboard: read order, bundle contents, write-back delay, done/busy edges.
    always @(negedge clk) begin
        if (mon_en) begin
            mk = edge_n - e0;
            chk("wr_eq_rd_3ago", 128'(wr_pack), 128'(hist[2]));
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = rd_pack;
            if (bus.rd_valid) begin
                m_seen = '0;
                m_ok   = 1'b1;
                for (int l = 0; l < 8; l++) begin
                    m_seen[bus.rd_lane_bank[l]] = 1'b1;
                    if (int'(bus.rd_sel_a[bus.rd_lane_bank[l]]) != l) m_ok = 1'b0;
                end
                chk("banks_distinct", {m_ok, m_seen}, {1'b1, 8'hFF});
                if (rdq.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    m_e = rdq.pop_front();
                    model(m_e.s, m_e.c, m_b, m_lb, m_sel);
                    chk("rd_b", bus.rd_b, pk2(m_b));
                    chk("rd_lane_bank", bus.rd_lane_bank, pk3(m_lb));
                    chk("rd_sel_a", bus.rd_sel_a, pk3(m_sel));
                    cap_b[m_e.s][m_e.c]   = bus.rd_b;
                    cap_lb[m_e.s][m_e.c]  = bus.rd_lane_bank;
                    cap_sel[m_e.s][m_e.c] = bus.rd_sel_a;
                    cap_ok[m_e.s][m_e.c]  = 1'b1;
                    if (m_e.c == 0) first_rd[m_e.s] = mk;
                end
                last_rd = mk;
                wrq.push_back(mk);
            end
            if (bus.wr_valid) begin
                if (wrq.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    mkr = wrq.pop_front();
                    chk("wr_latency", mk - mkr, LAT);
                end
            end
            if (bus.done) begin
                chk("done_with_wr", bus.wr_valid, 1);
                if (done_k < 0) done_k = mk;
            end
            if (busy_prev && !bus.busy && busy_fall < 0) busy_fall = mk;
            busy_prev = bus.busy;
        end
    end

    task automatic arm_run();
        rdq.delete();
        wrq.delete();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        for (int s = 0; s < NST; s++) begin
            first_rd[s] = -1;
            for (int c = 0; c < NC; c++) rdq.push_back('{s: s, c: c});
        end
        done_k    = -1;
        busy_fall = -1;
        last_rd   = -1;
        busy_prev = 1'b0;
    endtask

    task automatic do_run(input string tag, input int hold_k, input int spur_k);
        int k, shift;
        shift = (hold_k >= 0) ? 5 : 0;
        arm_run();
        @(negedge clk);
        e0        = edge_n + 1;
        mon_en    = 1'b1;
        bus.start = 1'b1;
        k = -1;
        while (done_k < 0 && k < 200) begin
            @(negedge clk);
            k = edge_n - e0;
            if (k == 0) bus.start = 1'b0;
            if (k == spur_k) bus.start = 1'b1;
            if (k == spur_k + 1) bus.start = 1'b0;
            if (hold_k >= 0) begin
                if (k > hold_k && k <= hold_k + 5) chk({tag, "_hold_rdv"}, bus.rd_valid, 0);
                if (k == hold_k) bus.hold = 1'b1;
                if (k == hold_k + 5) bus.hold = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk({tag, "_done_edge"}, done_k, 39 + shift);
        chk({tag, "_busy_fall"}, busy_fall, 39 + shift);
        chk({tag, "_last_rd"}, last_rd, 36 + shift);
        for (int s = 0; s < NST; s++)
            chk({tag, "_stage_first_rd"}, first_rd[s], 1 + 8 * s + ((s > 0) ? shift : 0));
        chk({tag, "_rd_left"}, rdq.size(), 0);
        chk({tag, "_wr_left"}, wrq.size(), 0);
        chk({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{s: 0, c: 0, b: '{0,0,0,0,0,0,0,0}, lb: '{0,1,2,3,4,5,6,7},
                   sel: '{0,1,2,3,4,5,6,7}};
        tbl[1] = '{s: 2, c: 1, b: '{1,1,1,1,1,1,1,1}, lb: '{4,0,5,1,6,2,7,3},
                   sel: '{1,3,5,7,0,2,4,6}};
        tbl[2] = '{s: 4, c: 3, b: '{1,3,1,3,1,3,1,3}, lb: '{0,4,1,5,2,6,3,7},
                   sel: '{0,2,4,6,1,3,5,7}};
        for (int s = 0; s < NST; s++)
            for (int c = 0; c < NC; c++) cap_ok[s][c] = 1'b0;

        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd", rd_pack, 0);
        chk("rst_wr", wr_pack, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run("plain", -1, -100);
        for (int i = 0; i < 3; i++) begin
            chk("tbl_seen", cap_ok[tbl[i].s][tbl[i].c], 1);
            chk("tbl_rd_b", cap_b[tbl[i].s][tbl[i].c], pk2(tbl[i].b));
            chk("tbl_lane_bank", cap_lb[tbl[i].s][tbl[i].c], pk3(tbl[i].lb));
            chk("tbl_sel_a", cap_sel[tbl[i].s][tbl[i].c], pk3(tbl[i].sel));
        end

        do_run("hold", 2, -100);
        do_run("spur_start", -1, 20);

        // Reset asserted mid-run, just before E10.
        arm_run();
        @(negedge clk);
        e0        = edge_n + 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (edge_n - e0 < 9) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_rd", rd_pack, 0);
        chk("midrst_wr", wr_pack, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_wr_valid", bus.wr_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        do_run("after_rst", -1, -100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
